// File: rtl/serial_rx_capture.sv
// serial_rx_capture: 8N1 UART receiver feeding a first-word-fall-through FIFO with sticky error flags.
// Define SERIAL_RX_RTS_EN to build the hysteresis flow-control output on rts.
module serial_rx_capture #(
    parameter int BIT_CYCLES = 87,
    parameter int DEPTH      = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rxd,
    input  logic                     rd_en,
    input  logic                     clr_err,
    output logic [7:0]               rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     frame_err,
    output logic                     overrun,
    output logic                     rts
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(BIT_CYCLES + 1);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
    state_t          state;
    logic            s1, s2, rx_d;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wp, rp;
    logic            done, push, ferr_set, pop, wr, ovr_set;
    wire rx = s2;
    assign done     = cnt == CW'(1);
    assign push     = state == STOP && done && rx;
    assign ferr_set = state == STOP && done && !rx;
    assign empty    = count == '0;
    assign full     = count == (AW+1)'(DEPTH);
    assign pop      = rd_en && !empty;
    assign wr       = push && (!full || rd_en);
    assign ovr_set  = push && full && !rd_en;
    assign rd_data  = empty ? 8'h00 : mem[rp];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            s1   <= rxd;
            s2   <= s1;
            rx_d <= s2;
        end
    end
    // Counter counts down to 1; the sample is taken on the cycle it reads 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                IDLE: if (rx_d && !rx) begin
                    state <= START;
                    cnt   <= CW'(BIT_CYCLES / 2);
                end
                START: if (done) begin
                    state   <= rx ? IDLE : DATA;
                    cnt     <= CW'(BIT_CYCLES);
                    bit_idx <= '0;
                end else cnt <= cnt - 1'b1;
                DATA: if (done) begin
                    shreg   <= {rx, shreg[7:1]};
                    bit_idx <= bit_idx + 1'b1;
                    cnt     <= CW'(BIT_CYCLES);
                    if (bit_idx == 3'd7) state <= STOP;
                end else cnt <= cnt - 1'b1;
                STOP: if (done) state <= rx ? IDLE : BREAK;
                else cnt <= cnt - 1'b1;
                BREAK: if (rx) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) if (wr) mem[wp] <= shreg;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp        <= '0;
            rp        <= '0;
            count     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            wp        <= wr ? wp + 1'b1 : wp;
            rp        <= pop ? rp + 1'b1 : rp;
            count     <= count + (AW+1)'(wr) - (AW+1)'(pop);
            frame_err <= ferr_set | (frame_err & !clr_err);
            overrun   <= ovr_set | (overrun & !clr_err);
        end
    end
`ifdef SERIAL_RX_RTS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rts <= 1'b0;
        else rts <= count >= (AW+1)'(DEPTH - 4) ? 1'b1 : count <= (AW+1)'(DEPTH / 2) ? 1'b0 : rts;
    end
`else
    assign rts = 1'b0;
`endif
endmodule

// File: tb/tb_serial_rx_capture.sv
// tb_serial_rx_capture: directed scoreboard bench for serial_rx_capture.
module tb_serial_rx_capture;
    localparam int BC = 87;
    localparam int DEPTH = 16;
    logic       clk = 1'b0;
    logic       reset, rxd, rd_en, clr_err;
    logic [7:0] rd_data;
    logic       empty, full, frame_err, overrun, rts;
    logic [4:0] count;
    int         checks = 0;
    int         fails = 0;
    logic [7:0] exp_q[$];
    serial_rx_capture #(.BIT_CYCLES(BC), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .rxd(rxd), .rd_en(rd_en), .clr_err(clr_err),
        .rd_data(rd_data), .empty(empty), .full(full), .count(count),
        .frame_err(frame_err), .overrun(overrun), .rts(rts)
    );
    always #5 clk = ~clk;
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic send(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        cycles(BC);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            cycles(BC);
        end
        rxd = stop;
        cycles(BC);
        if (stop && exp_q.size() < DEPTH) exp_q.push_back(b);
    endtask
    task automatic pop_chk(input string tag);
        logic [7:0] e;
        e = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
        chk(tag, {24'h0, rd_data}, {24'h0, e});
        rd_en = 1'b1;
        cycles(1);
        rd_en = 1'b0;
    endtask
    task automatic pulse_clr();
        clr_err = 1'b1;
        cycles(1);
        clr_err = 1'b0;
        cycles(1);
    endtask
    initial begin
        reset = 1'b1; rxd = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
        cycles(3);
        chk("rst_empty", empty, 1);
        chk("rst_count", count, 0);
        chk("rst_full", full, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rts", rts, 0);
        reset = 1'b0;
        cycles(10);
        // single byte, then read it back
        send(8'h41, 1'b1);
        chk("b41_empty", empty, 0);
        chk("b41_count", count, 1);
        pop_chk("b41_data");
        chk("b41_empty_after", empty, 1);
        rd_en = 1'b1;
        cycles(1);
        rd_en = 1'b0;
        chk("underflow_count", count, 0);
        // start-bit glitch
        rxd = 1'b0;
        cycles(20);
        rxd = 1'b1;
        cycles(200);
        chk("glitch_count", count, 0);
        chk("glitch_ferr", frame_err, 0);
        chk("glitch_ovr", overrun, 0);
        // framing error and break
        send(8'h55, 1'b0);
        cycles(300);
        chk("brk_ferr", frame_err, 1);
        chk("brk_count", count, 0);
        rxd = 1'b1;
        cycles(20);
        chk("brk_count_idle", count, 0);
        send(8'h0D, 1'b1);
        chk("b0d_count", count, 1);
        pop_chk("b0d_data");
        pulse_clr();
        chk("ferr_clr", frame_err, 0);
        // overrun
        for (int i = 0; i < 17; i++) send(8'(i), 1'b1);
        cycles(3);
        chk("ovr_full", full, 1);
        chk("ovr_count", count, 16);
        chk("ovr_flag", overrun, 1);
        chk("ovr_ferr", frame_err, 0);
`ifdef SERIAL_RX_RTS_EN
        chk("rts_full", rts, 1);
`else
        chk("rts_full_off", rts, 0);
`endif
        for (int i = 0; i < 16; i++) begin
            pop_chk($sformatf("fifo_%0d", i));
            cycles(2);
`ifdef SERIAL_RX_RTS_EN
            if (i == 6) chk("rts_at9", rts, 1);
            if (i == 7) chk("rts_at8", rts, 0);
`else
            if (i == 6 || i == 7) chk("rts_off", rts, 0);
`endif
        end
        chk("drain_empty", empty, 1);
        chk("drain_count", count, 0);
        pulse_clr();
        chk("ovr_clr", overrun, 0);
        // reset during data bit 4 of 8'hA5
        rxd = 1'b0;
        cycles(BC);
        for (int i = 0; i < 4; i++) begin
            rxd = 1'(8'hA5 >> i);
            cycles(BC);
        end
        rxd = 1'b0;
        cycles(40);
        reset = 1'b1;
        #2;
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_rd_data", rd_data, 0);
        rxd = 1'b1;
        cycles(5);
        reset = 1'b0;
        cycles(BC * 6);
        chk("mid_rst_nopush", count, 0);
        send(8'h5A, 1'b1);
        chk("b5a_count", count, 1);
        pop_chk("b5a_data");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
